// File: rtl/snake_dir_if.sv
`default_nettype none
// ============================================================================
// Module   : snake_dir_if
// Purpose  : Groups the scan-code input strobe, the game tick and the
//            scheduler status outputs into one bundle.
// Ports    : scan_code/scan_valid   - received PS/2 byte and its strobe
//            game_tick              - one-cycle strobe from the game timer
//            direction/dir_update   - current direction and update pulse
//            paused                 - pause state
//            q_count                - number of queued turns
//            drop                   - turn discarded because the FIFO is full
//            master modport drives the inputs; slave is the scheduler side.
// Revision : 1.0 - initial release
// ============================================================================
interface snake_dir_if #(
  parameter int QDEPTH = 4
) ();
  logic [7:0]                     scan_code;
  logic                           scan_valid;
  logic                           game_tick;
  logic [2:0]                     direction;
  logic                           dir_update;
  logic                           paused;
  logic [$clog2(QDEPTH+1)-1:0]    q_count;
  logic                           drop;

  modport master (
    output scan_code, scan_valid, game_tick,
    input  direction, dir_update, paused, q_count, drop
  );

  modport slave (
    input  scan_code, scan_valid, game_tick,
    output direction, dir_update, paused, q_count, drop
  );
endinterface
`default_nettype wire

// File: rtl/snake_dir_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : snake_dir_scheduler
// Purpose  : Decodes PS/2 make/break/extended scan-code sequences into
//            direction and pause commands, rejects same-axis turns, queues
//            accepted turns and applies one per game tick.
// Ports    : clk - system clock
//            rst - asynchronous active-low reset
//            bus - snake_dir_if slave (scan input, tick, status outputs)
// Revision : 1.0 - initial release
// ============================================================================
module snake_dir_scheduler #(
  parameter int QDEPTH  = 4,
  parameter int TIMEOUT = 50000
) (
  input  logic          clk,
  input  logic          rst,
  snake_dir_if.slave    bus
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH+1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] c_up    = 3'b011;
  localparam logic [2:0] c_left  = 3'b010;
  localparam logic [2:0] c_down  = 3'b001;
  localparam logic [2:0] c_right = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BRK     = 2'd1,
    S_EXT     = 2'd2,
    S_EXT_BRK = 2'd3
  } dec_state_t;

  dec_state_t       r_state;
  dec_state_t       w_state_nxt;
  logic [TW-1:0]    r_to_cnt;
  logic             w_emit_dir;
  logic [2:0]       w_dir;
  logic             w_emit_pause;

  logic [2:0]       r_mem [QDEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [2:0]       r_direction;
  logic             r_dir_update;
  logic             r_paused;
  logic             r_drop;

  logic [AW-1:0]    w_tail_idx;
  logic [2:0]       w_ref;
  logic             w_accept;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;

  // Decoder state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Decoder next-state and command emission
  always_comb begin
    w_state_nxt  = r_state;
    w_emit_dir   = 1'b0;
    w_dir        = c_right;
    w_emit_pause = 1'b0;
    if (bus.scan_valid) begin
      case (r_state)
        S_IDLE: begin
          case (bus.scan_code)
            8'hF0:   w_state_nxt = S_BRK;
            8'hE0:   w_state_nxt = S_EXT;
            8'h1D:   begin w_emit_dir = 1'b1; w_dir = c_up;    end
            8'h1C:   begin w_emit_dir = 1'b1; w_dir = c_left;  end
            8'h1B:   begin w_emit_dir = 1'b1; w_dir = c_down;  end
            8'h23:   begin w_emit_dir = 1'b1; w_dir = c_right; end
            8'h29:   w_emit_pause = 1'b1;
            default: w_state_nxt = S_IDLE;
          endcase
        end
        S_EXT: begin
          w_state_nxt = S_IDLE;
          case (bus.scan_code)
            8'hF0:   w_state_nxt = S_EXT_BRK;
            8'h75:   begin w_emit_dir = 1'b1; w_dir = c_up;    end
            8'h6B:   begin w_emit_dir = 1'b1; w_dir = c_left;  end
            8'h72:   begin w_emit_dir = 1'b1; w_dir = c_down;  end
            8'h74:   begin w_emit_dir = 1'b1; w_dir = c_right; end
            default: w_state_nxt = S_IDLE;
          endcase
        end
        // Released key codes are swallowed without effect.
        default: w_state_nxt = S_IDLE;
      endcase
    end else if (r_state != S_IDLE && r_to_cnt == TW'(TIMEOUT-1)) begin
      // A prefix whose follow-up byte never arrived is abandoned.
      w_state_nxt = S_IDLE;
    end
  end

  // Prefix timeout counter: runs only while a sequence is pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                           r_to_cnt <= '0;
    else if (bus.scan_valid || w_state_nxt == S_IDLE)   r_to_cnt <= '0;
    else                                                r_to_cnt <= r_to_cnt + TW'(1);
  end

  // Turn filter: compare against the newest queued turn, or the live
  // direction when nothing is queued. Only axis changes are accepted.
  assign w_tail_idx = r_wr_ptr - AW'(1);
  assign w_ref      = (r_count != '0) ? r_mem[w_tail_idx] : r_direction;
  assign w_accept   = w_emit_dir && (w_dir[0] != w_ref[0]);
  assign w_full     = (r_count == CW'(QDEPTH));
  assign w_pop      = bus.game_tick && !r_paused && (r_count != '0);
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign w_push     = w_accept && (!w_full || w_pop);
  assign w_drop     = w_accept && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_dir;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_direction  <= c_right;
      r_dir_update <= 1'b0;
      r_paused     <= 1'b0;
      r_drop       <= 1'b0;
    end else begin
      r_dir_update <= 1'b0;
      r_drop       <= w_drop;
      if (w_emit_pause) r_paused <= ~r_paused;
      if (w_push)       r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr     <= r_rd_ptr + AW'(1);
        r_direction  <= r_mem[r_rd_ptr];
        r_dir_update <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.direction  = r_direction;
  assign bus.dir_update = r_dir_update;
  assign bus.paused     = r_paused;
  assign bus.q_count    = r_count;
  assign bus.drop       = r_drop;
endmodule
`default_nettype wire

// File: tb/tb_snake_dir_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_dir_scheduler
// Purpose  : Directed scoreboard bench for snake_dir_scheduler. Expected
//            direction updates and drop pulses are queued by the stimulus
//            and consumed by a monitor whenever the DUT pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snake_dir_scheduler;
  localparam int QDEPTH  = 4;
  localparam int TIMEOUT = 16;

  logic clk;
  logic rst;

  int total;
  int bad;
  int exp_dir[$];
  bit exp_drop[$];

  snake_dir_if #(.QDEPTH(QDEPTH)) bus ();

  snake_dir_scheduler #(
    .QDEPTH (QDEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every output pulse must match a queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (bus.dir_update === 1'b1) begin
        if (exp_dir.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_dir_update: got direction %0d expected no pulse", bus.direction);
        end else begin
          chk("dir_update_direction", int'(bus.direction), exp_dir.pop_front());
        end
      end
      if (bus.drop === 1'b1) begin
        if (exp_drop.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_drop: got 1 expected 0");
        end else begin
          void'(exp_drop.pop_front());
          total++;
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic with_tick = 1'b0);
    @(negedge clk);
    bus.scan_code  = b;
    bus.scan_valid = 1'b1;
    bus.game_tick  = with_tick;
    @(negedge clk);
    bus.scan_valid = 1'b0;
    bus.game_tick  = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    bus.game_tick = 1'b1;
    @(negedge clk);
    bus.game_tick = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_direction"},  int'(bus.direction),  0);
    chk({tag, "_dir_update"}, int'(bus.dir_update), 0);
    chk({tag, "_paused"},     int'(bus.paused),     0);
    chk({tag, "_q_count"},    int'(bus.q_count),    0);
    chk({tag, "_drop"},       int'(bus.drop),       0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst            = 1'b0;
    bus.scan_code  = 8'h00;
    bus.scan_valid = 1'b0;
    bus.game_tick  = 1'b0;
    do_reset();

    // Reversal / same-direction from right are rejected.
    send(8'h1C); chk("rev_left_q", int'(bus.q_count), 0);
    send(8'h23); chk("same_right_q", int'(bus.q_count), 0);
    tick();
    chk("rev_dir_kept", int'(bus.direction), 0);

    // Single turn up.
    send(8'h1D); chk("up_q1", int'(bus.q_count), 1);
    exp_dir.push_back(3);
    tick();
    chk("up_dir", int'(bus.direction), 3);
    chk("up_q0", int'(bus.q_count), 0);

    // Three fast turns from a fresh reset.
    do_reset();
    send(8'h1D); send(8'h1C); send(8'h1B);
    chk("three_q", int'(bus.q_count), 3);
    exp_dir.push_back(3); exp_dir.push_back(2); exp_dir.push_back(1);
    repeat (3) tick();
    chk("three_dir", int'(bus.direction), 1);
    chk("three_q0", int'(bus.q_count), 0);
    send(8'h23); exp_dir.push_back(0); tick();
    chk("back_right", int'(bus.direction), 0);

    // Break and extended-break sequences queue nothing; E0 75 queues up.
    send(8'hF0); send(8'h1D);
    chk("brk_q", int'(bus.q_count), 0);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("extbrk_q", int'(bus.q_count), 0);
    send(8'hE0); send(8'h75);
    chk("ext_up_q", int'(bus.q_count), 1);
    exp_dir.push_back(3); tick();
    chk("ext_up_dir", int'(bus.direction), 3);

    // Fill the FIFO, overflow once, then push with a simultaneous pop.
    send(8'h23); send(8'h1D); send(8'h23); send(8'h1D);
    chk("full_q", int'(bus.q_count), 4);
    exp_drop.push_back(1'b1);
    send(8'h23);
    chk("overflow_q", int'(bus.q_count), 4);
    exp_dir.push_back(0);
    send(8'h23, 1'b1);
    chk("pushpop_q", int'(bus.q_count), 4);
    chk("pushpop_dir", int'(bus.direction), 0);
    exp_dir.push_back(3); exp_dir.push_back(0);
    exp_dir.push_back(3); exp_dir.push_back(0);
    repeat (4) tick();
    chk("drain_q", int'(bus.q_count), 0);
    chk("drain_dir", int'(bus.direction), 0);

    // Pause holds the queue; resume applies it.
    send(8'h29); chk("pause_on", int'(bus.paused), 1);
    send(8'h1D); chk("pause_q", int'(bus.q_count), 1);
    repeat (2) tick();
    chk("pause_q_kept", int'(bus.q_count), 1);
    chk("pause_dir_kept", int'(bus.direction), 0);
    send(8'h29); chk("pause_off", int'(bus.paused), 0);
    exp_dir.push_back(3); tick();
    chk("resume_dir", int'(bus.direction), 3);
    chk("resume_q", int'(bus.q_count), 0);

    // Abandoned E0 prefix: the following byte decodes from IDLE.
    send(8'h1C); exp_dir.push_back(2); tick();
    send(8'hE0);
    repeat (TIMEOUT + 4) @(negedge clk);
    send(8'h1B);
    chk("timeout_q", int'(bus.q_count), 1);
    exp_dir.push_back(1); tick();
    chk("timeout_dir", int'(bus.direction), 1);

    // Asynchronous reset in the middle of an extended sequence.
    send(8'h1C);
    chk("prerst_q", int'(bus.q_count), 1);
    send(8'hE0);
    #2 rst = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b1;
    tick();
    send(8'h75);
    chk("post_rst_q", int'(bus.q_count), 0);

    repeat (4) @(negedge clk);
    chk("leftover_dir_exp", exp_dir.size(), 0);
    chk("leftover_drop_exp", exp_drop.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
